// File: rtl/demux14_stream.sv
// 1-to-4 stream demultiplexer: each accepted word is steered by in_sel into a
// one-deep per-channel output buffer, with saturating per-channel word counters.
module demux14_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    input  logic [1:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_out,
    input  logic                 cnt_clr
);

    logic [3:0]       vld_q, vld_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];
    logic [3:0]       load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Only the addressed channel gates acceptance, so a stalled channel never blocks the others.
    assign in_ready = !vld_q[in_sel] || out_ready[in_sel];

    always_comb begin
        load = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            load[k]   = in_valid && in_ready && (in_sel == 2'(k));
            vld_d[k]  = load[k] || (vld_q[k] && !out_ready[k]);
            data_d[k] = load[k] ? in_data : data_q[k];
            if (cnt_clr)
                cnt_d[k] = '0;
            else if (load[k])
                cnt_d[k] = sat_inc(cnt_q[k]);
            else
                cnt_d[k] = cnt_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++)
            out_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign out_valid = vld_q;
    assign cnt_out   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_demux14_stream.sv
// Directed bench for demux14_stream: per-channel behavioural model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_demux14_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         cnt_sel;
    logic [CNT_W-1:0]   cnt_out;
    logic               cnt_clr;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: whether each channel holds a word, that word, and its accept count.
    logic       m_vld  [4];
    logic [3:0] m_data [4];
    int         m_cnt  [4];

    demux14_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out),
        .cnt_clr  (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit takes(input int k);
        return in_valid && (int'(in_sel) == k) && (!m_vld[k] || out_ready[k]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_vld[k] <= 1'b0;
                m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (takes(k)) begin
                    m_vld[k]  <= 1'b1;
                    m_data[k] <= in_data;
                end else if (out_ready[k]) begin
                    m_vld[k] <= 1'b0;
                end
                if (cnt_clr) m_cnt[k] <= 0;
                else if (takes(k) && m_cnt[k] < CMAX) m_cnt[k] <= m_cnt[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid),
            int'({m_vld[3], m_vld[2], m_vld[1], m_vld[0]}));
        for (int k = 0; k < 4; k++)
            if (m_vld[k]) chk("out_data", int'(out_data[k*WIDTH +: WIDTH]), int'(m_data[k]));
        chk("in_ready", int'(in_ready), int'(!m_vld[in_sel] || out_ready[in_sel]));
        chk("cnt_out", int'(cnt_out), m_cnt[cnt_sel]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [3:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        cyc();
    endtask

    function automatic int chan(input int k);
        return int'(out_data[k*WIDTH +: WIDTH]);
    endfunction

    initial begin
        rst_n = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
        out_ready = 4'b0000; cnt_sel = '0; cnt_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1 chk("rst_cnt", int'(cnt_out), 0);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Basic routing
        out_ready = 4'b1111;
        send(2'b10, 4'b0010);
        chk("route0_vld", int'(out_valid), 4'b0100); chk("route0_d", chan(2), 4'b0010);
        send(2'b10, 4'b0111);
        chk("route1_vld", int'(out_valid), 4'b0100); chk("route1_d", chan(2), 4'b0111);
        send(2'b00, 4'b1010);
        chk("route2_vld", int'(out_valid), 4'b0001); chk("route2_d", chan(0), 4'b1010);
        send(2'b01, 4'b0011);
        chk("route3_vld", int'(out_valid), 4'b0010); chk("route3_d", chan(1), 4'b0011);
        in_valid = 1'b0;
        cyc();
        chk("route_idle", int'(out_valid), 0);
        cnt_sel = 2'd2; #1 chk("cnt_ch2", int'(cnt_out), 2);
        cnt_sel = 2'd0; #1 chk("cnt_ch0", int'(cnt_out), 1);
        cnt_sel = 2'd1; #1 chk("cnt_ch1", int'(cnt_out), 1);
        cnt_sel = 2'd3; #1 chk("cnt_ch3", int'(cnt_out), 0);

        // Backpressure isolation
        out_ready = 4'b1110;
        send(2'b00, 4'b0101);
        in_data = 4'b1100;
        #1 chk("bp_in_ready", int'(in_ready), 0);
        cyc();
        chk("bp_hold_vld", int'(out_valid[0]), 1); chk("bp_hold_d", chan(0), 4'b0101);
        in_sel = 2'b11; in_data = 4'b1001;
        #1 chk("bp_other_ready", int'(in_ready), 1);
        cyc();
        chk("bp_ch3_vld", int'(out_valid), 4'b1001); chk("bp_ch3_d", chan(3), 4'b1001);
        chk("bp_ch0_still", chan(0), 4'b0101);
        out_ready = 4'b1111;
        send(2'b00, 4'b1100);
        chk("bp_release_vld", int'(out_valid), 4'b0001); chk("bp_release_d", chan(0), 4'b1100);

        // Load and drain on the same edge
        send(2'b01, 4'b0001);
        chk("ld_first", chan(1), 4'b0001);
        send(2'b01, 4'b1111);
        chk("ld_vld", int'(out_valid[1]), 1); chk("ld_d", chan(1), 4'b1111);
        in_valid = 1'b0;
        cyc();

        // Saturation and clear
        cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(2'b10, 4'(i + 3));
        cnt_sel = 2'd2;
        #1 chk("sat_cnt", int'(cnt_out), 3);
        cnt_clr = 1'b1;
        send(2'b10, 4'b1110);
        cnt_clr = 1'b0; in_valid = 1'b0;
        chk("clr_vld", int'(out_valid[2]), 1); chk("clr_d", chan(2), 4'b1110);
        #1 chk("clr_cnt", int'(cnt_out), 0);
        cyc();

        // Asynchronous reset mid-operation
        out_ready = 4'b0110;
        send(2'b00, 4'b0110);
        send(2'b11, 4'b1000);
        in_valid = 1'b0;
        chk("ar_full", int'(out_valid), 4'b1001);
        #2 rst_n = 1'b0;
        #1 chk("ar_vld", int'(out_valid), 0);
        cyc();
        rst_n = 1'b1;
        out_ready = 4'b1111;
        send(2'b00, 4'b0011);
        in_valid = 1'b0;
        chk("ar_route_vld", int'(out_valid), 4'b0001); chk("ar_route_d", chan(0), 4'b0011);
        cnt_sel = 2'd0;
        #1 chk("ar_cnt", int'(cnt_out), 1);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
